// File: rtl/axil_mil_reg_slave.sv
// AXI4-Lite register bank slave.
// Independent write/read engines, one outstanding transaction each.
module axil_mil_reg_slave #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int NREGS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [AW-1:0]       awaddr,
    input  logic [2:0]          awprot,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DW-1:0]       wdata,
    input  logic [DW/8-1:0]     wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [AW-1:0]       araddr,
    input  logic [2:0]          arprot,
    output logic                rvalid,
    input  logic                rready,
    output logic [DW-1:0]       rdata,
    output logic [1:0]          rresp,
    output logic [NREGS*DW-1:0] reg_q,
    output logic [NREGS-1:0]    reg_wr
);

    localparam int SW  = DW / 8;
    localparam int OFF = $clog2(SW);
    localparam int IW  = $clog2(NREGS);
    localparam logic [AW-1:0] LIMIT = AW'(NREGS * SW);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate, wstate_d;
    rstate_t rstate, rstate_d;

    logic          aw_got, aw_got_d, w_got, w_got_d;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;

    logic          aw_hs, w_hs, ar_hs, commit, wr_hit, rd_hit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [IW-1:0] wr_idx, rd_idx;

    logic [DW-1:0] regs [NREGS];

    logic unused_prot;
    assign unused_prot = ^{awprot, arprot};

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_q
        assign reg_q[gi*DW +: DW] = regs[gi];
    end

    assign bvalid = (wstate == W_RESP);
    assign rvalid = (rstate == R_DATA);

    // Write engine: merge captured/live AW and W, decide commit and next state
    always_comb begin
        aw_hs    = awvalid & awready;
        w_hs     = wvalid & wready;
        wr_addr  = aw_got ? aw_addr_q : awaddr;
        wr_data  = w_got ? w_data_q : wdata;
        wr_strb  = w_got ? w_strb_q : wstrb;
        wr_idx   = wr_addr[OFF +: IW];
        commit   = (wstate == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
        wr_hit   = commit && (wr_addr < LIMIT);
        wstate_d = wstate;
        aw_got_d = aw_got;
        w_got_d  = w_got;
        unique case (wstate)
            W_IDLE: begin
                if (commit) begin
                    wstate_d = W_RESP;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end else begin
                    aw_got_d = aw_got | aw_hs;
                    w_got_d  = w_got | w_hs;
                end
            end
            W_RESP: if (bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write engine state, holding registers, registered readies and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate    <= W_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bresp     <= 2'b00;
        end else begin
            wstate  <= wstate_d;
            aw_got  <= aw_got_d;
            w_got   <= w_got_d;
            awready <= (wstate_d == W_IDLE) && !aw_got_d;
            wready  <= (wstate_d == W_IDLE) && !w_got_d;
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) bresp <= wr_hit ? 2'b00 : 2'b10;
        end
    end

    // Register bank byte-masked update and one-cycle write pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            reg_wr <= '0;
        end else begin
            reg_wr <= '0;
            if (wr_hit) begin
                reg_wr[wr_idx] <= 1'b1;
                for (int b = 0; b < SW; b++) begin
                    if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read engine next-state
    always_comb begin
        ar_hs    = arvalid & arready;
        rd_idx   = araddr[OFF +: IW];
        rd_hit   = araddr < LIMIT;
        rstate_d = rstate;
        unique case (rstate)
            R_IDLE: if (ar_hs) rstate_d = R_DATA;
            R_DATA: if (rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read engine state, ready and data capture (pre-edge register value)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            rstate  <= rstate_d;
            arready <= (rstate_d == R_IDLE);
            if (ar_hs) begin
                rdata <= rd_hit ? regs[rd_idx] : '0;
                rresp <= rd_hit ? 2'b00 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_axil_mil_reg_slave.sv
// Scoreboard bench for axil_mil_reg_slave.
// Drivers push expectations; B/R monitors pop and compare.
module tb_axil_mil_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           awvalid = 1'b0;
    logic           awready;
    logic [AW-1:0]  awaddr = '0;
    logic [2:0]     awprot = 3'b000;
    logic           wvalid = 1'b0;
    logic           wready;
    logic [DW-1:0]  wdata = '0;
    logic [3:0]     wstrb = '0;
    logic           bvalid;
    logic           bready = 1'b0;
    logic [1:0]     bresp;
    logic           arvalid = 1'b0;
    logic           arready;
    logic [AW-1:0]  araddr = '0;
    logic [2:0]     arprot = 3'b000;
    logic           rvalid;
    logic           rready = 1'b0;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]  reg_wr;

    axil_mil_reg_slave #(.AW(AW), .DW(DW), .NREGS(NR)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_q(reg_q), .reg_wr(reg_wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] model [NR];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    int bmode = 1;
    int rmode = 1;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    function automatic logic [511:0] flat();
        logic [511:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
    endtask

    // B channel monitor: randomise/hold bready, compare held response
    always @(negedge clk) begin
        bready = (bmode == 0) ? 1'($urandom_range(0, 1)) : (bmode == 1);
        if (bvalid) begin
            if (bq.size() == 0) begin
                timeout("b_unexpected");
            end else begin
                chk("bresp", 512'(bresp), 512'(bq[0]));
                if (bready) void'(bq.pop_front());
            end
        end
    end

    // R channel monitor
    always @(negedge clk) begin
        rready = (rmode == 0) ? 1'($urandom_range(0, 1)) : (rmode == 1);
        if (rvalid) begin
            if (rq.size() == 0) begin
                timeout("r_unexpected");
            end else begin
                chk("rdata", 512'(rdata), 512'(rq[0][31:0]));
                chk("rresp", 512'(rresp), 512'(rq[0][33:32]));
                if (rready) void'(rq.pop_front());
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aw_dly,
                            input int w_dly);
        logic [15:0] exp_wr;
        int idx;
        exp_wr = '0;
        if (a < 32'(NR * 4)) begin
            idx = int'(a / 4);
            exp_wr[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b10);
        end
        @(negedge clk);
        fork
            begin
                int n;
                n = 0;
                repeat (aw_dly) @(negedge clk);
                awvalid = 1'b1;
                awaddr = a;
                while (!awready && n <= 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n > 100) timeout("awready");
                @(posedge clk);
                #1 awvalid = 1'b0;
                if (w_dly > aw_dly) chk("awready_drop", 512'(awready), 512'(0));
            end
            begin
                int n;
                n = 0;
                repeat (w_dly) @(negedge clk);
                wvalid = 1'b1;
                wdata = d;
                wstrb = s;
                while (!wready && n <= 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n > 100) timeout("wready");
                @(posedge clk);
                #1 wvalid = 1'b0;
                if (aw_dly > w_dly) chk("wready_drop", 512'(wready), 512'(0));
            end
        join
        chk("bvalid_lat", 512'(bvalid), 512'(1));
        chk("reg_wr", 512'(reg_wr), 512'(exp_wr));
        chk("reg_q", reg_q, flat());
        @(posedge clk);
        #1 chk("reg_wr_clr", 512'(reg_wr), 512'(0));
    endtask

    task automatic push_read_exp(input logic [31:0] a);
        if (a < 32'(NR * 4)) rq.push_back({2'b00, model[a / 4]});
        else rq.push_back({2'b10, 32'h0});
    endtask

    task automatic ar_issue(input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk);
        arvalid = 1'b1;
        araddr = a;
        while (!arready && n <= 100) begin
            @(negedge clk);
            n++;
        end
        if (n > 100) timeout("arready");
        @(posedge clk);
        #1 arvalid = 1'b0;
        chk("rvalid_lat", 512'(rvalid), 512'(1));
    endtask

    task automatic do_read(input logic [31:0] a);
        push_read_exp(a);
        ar_issue(a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 512'(bq.size() + rq.size()), 512'(0));
    endtask

    initial begin
        logic [31:0] a;
        model_reset();
        #1 rst = 1'b1;
        #12;
        chk("rst_awready", 512'(awready), 512'(0));
        chk("rst_bvalid", 512'(bvalid), 512'(0));
        chk("rst_rvalid", 512'(rvalid), 512'(0));
        chk("rst_regq", reg_q, 512'(0));
        chk("rst_rdata", 512'({rdata, rresp, bresp}), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rdy_rise", 512'({awready, wready, arready}), 512'(3'b111));

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("r1_const", 512'(reg_q[63:32]), 512'(32'hDEADBEEF));
        do_read(32'h04);
        drain();

        do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_write(32'h08, 32'h11223344, 4'b0101, 3, 0);
        chk("r2_const", 512'(reg_q[95:64]), 512'(32'hFF22FF44));
        drain();

        do_write(32'h40, 32'h12345678, 4'hF, 0, 0);
        do_read(32'h40);
        drain();

        bmode = 2;
        do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 1);
        awvalid = 1'b1;
        awaddr = 32'h14;
        repeat (5) begin
            @(negedge clk);
            chk("bhold_v", 512'(bvalid), 512'(1));
            chk("bhold_rdy", 512'({awready, wready}), 512'(0));
        end
        awvalid = 1'b0;
        bmode = 1;
        drain();
        do_write(32'h14, 32'h0BADC0DE, 4'hF, 1, 0);
        drain();

        rmode = 2;
        do_read(32'h04);
        arvalid = 1'b1;
        araddr = 32'h10;
        repeat (5) begin
            @(negedge clk);
            chk("rhold_v", 512'(rvalid), 512'(1));
            chk("rhold_rdy", 512'(arready), 512'(0));
        end
        arvalid = 1'b0;
        rmode = 1;
        drain();

        push_read_exp(32'h0C);
        fork
            ar_issue(32'h0C);
            do_write(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0);
        join
        drain();
        do_read(32'h0C);
        drain();

        do_write(32'h18, 32'h55667788, 4'h0, 0, 0);
        drain();

        bmode = 0;
        rmode = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 32'h4F);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a);
        end
        drain();
        chk("final_regq", reg_q, flat());

        bmode = 2;
        rmode = 2;
        do_write(32'h1C, 32'h13579BDF, 4'hF, 0, 0);
        do_read(32'h1C);
        #3 rst = 1'b1;
        bq.delete();
        rq.delete();
        model_reset();
        #1;
        chk("arst_valids", 512'({bvalid, rvalid}), 512'(0));
        chk("arst_regq", reg_q, 512'(0));
        chk("arst_rdys", 512'({awready, wready, arready}), 512'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("arst_rdys_hold", 512'({awready, wready, arready}), 512'(0));
        rst = 1'b0;
        bmode = 1;
        rmode = 1;
        @(posedge clk);
        #1 chk("arst_rdy_rise", 512'({awready, wready, arready}), 512'(3'b111));
        do_read(32'h1C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
